// File: rtl/coefficient_decoder.sv
// Collects a Huffman symbol plus its amplitude bits, applies the JPEG EXTEND rule,
// saturates to a signed coefficient and tracks the DC/AC position within an 8x8 block.
module coefficient_decoder #(
  parameter int COEF_WIDTH  = 8,
  parameter int MAX_DC_SSSS = 11,
  parameter int MAX_AC_SSSS = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   symbol,
  input  logic                         symbol_valid,
  output logic                         symbol_ready,
  input  logic                         bit_in,
  input  logic                         bit_valid,
  output logic                         bit_ready,
  output logic [3:0]                   r_value,
  output logic signed [COEF_WIDTH-1:0] coefficient,
  output logic                         is_new_coefficient,
  output logic                         block_done,
  output logic                         error
);

  typedef enum logic [1:0] {WAIT_SYM, GET_BITS, EMIT} state_t;

  localparam logic [3:0] MAX_DC  = 4'(MAX_DC_SSSS);
  localparam logic [3:0] MAX_AC  = 4'(MAX_AC_SSSS);
  localparam int         SAT_MAX = (1 << (COEF_WIDTH - 1)) - 1;
  localparam int         SAT_MIN = -(1 << (COEF_WIDTH - 1));

  state_t      state, state_n;
  logic [5:0]  pos, pos_n;
  logic [3:0]  r_lat, s_lat, cnt;
  logic [14:0] acc;

  logic        sym_acc, bit_acc, go_emit;
  logic [3:0]  cur_r, cur_s, r_emit;
  logic [15:0] fin_acc;
  logic [6:0]  sum;
  logic        done_n, err_n;
  int          v;
  logic signed [COEF_WIDTH-1:0] coef_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= WAIT_SYM;
    else      state <= state_n;
  end

  // The emission is computed on the accepting edge so the strobe is visible
  // throughout the EMIT cycle, giving the T+1 latency.
  always_comb begin
    sym_acc = symbol_ready & symbol_valid;
    bit_acc = bit_ready & bit_valid;
    state_n = state;
    go_emit = 1'b0;
    case (state)
      WAIT_SYM: if (sym_acc) begin
        state_n = (symbol[3:0] == 4'd0) ? EMIT : GET_BITS;
        go_emit = (symbol[3:0] == 4'd0);
      end
      GET_BITS: if (bit_acc && cnt == 4'd1) begin
        state_n = EMIT;
        go_emit = 1'b1;
      end
      EMIT:     state_n = WAIT_SYM;
      default:  state_n = WAIT_SYM;
    endcase

    cur_r   = sym_acc ? symbol[7:4] : r_lat;
    cur_s   = sym_acc ? symbol[3:0] : s_lat;
    fin_acc = sym_acc ? '0 : {acc, bit_in};

    v = int'(fin_acc);
    if (cur_s == 4'd0) v = 0;
    else if (v < (1 << (cur_s - 4'd1))) v = v - (1 << cur_s) + 1;
    if (v > SAT_MAX)      v = SAT_MAX;
    else if (v < SAT_MIN) v = SAT_MIN;
    coef_n = COEF_WIDTH'(v);

    sum    = {1'b0, pos} + {3'b000, cur_r} + 7'd1;
    r_emit = cur_r;
    done_n = 1'b0;
    err_n  = 1'b0;
    pos_n  = pos;
    if (pos == 6'd0) begin
      r_emit = '0;
      pos_n  = 6'd1;
      err_n  = (cur_s > MAX_DC);
    end else if (cur_r == 4'd0 && cur_s == 4'd0) begin
      done_n = 1'b1;
      pos_n  = '0;
    end else begin
      if (cur_s == 4'd0 && cur_r != 4'd15) err_n = 1'b1;
      if (cur_s > MAX_AC)                  err_n = 1'b1;
      if (sum >= 7'd64) begin
        done_n = 1'b1;
        pos_n  = '0;
        if (sum > 7'd64) err_n = 1'b1;
      end else begin
        pos_n = sum[5:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      symbol_ready       <= 1'b0;
      bit_ready          <= 1'b0;
      pos                <= '0;
      r_lat              <= '0;
      s_lat              <= '0;
      cnt                <= '0;
      acc                <= '0;
      r_value            <= '0;
      coefficient        <= '0;
      is_new_coefficient <= 1'b0;
      block_done         <= 1'b0;
      error              <= 1'b0;
    end else begin
      symbol_ready       <= (state_n == WAIT_SYM);
      bit_ready          <= (state_n == GET_BITS);
      is_new_coefficient <= go_emit;
      block_done         <= go_emit & done_n;
      if (sym_acc) begin
        r_lat <= symbol[7:4];
        s_lat <= symbol[3:0];
        cnt   <= symbol[3:0];
        acc   <= '0;
      end else if (bit_acc) begin
        acc <= fin_acc[14:0];
        cnt <= cnt - 4'd1;
      end
      if (go_emit) begin
        r_value     <= r_emit;
        coefficient <= coef_n;
        pos         <= pos_n;
        error       <= error | err_n;
      end
    end
  end

endmodule
